demux_stream_1ton: RTL
======================

# demux_stream_1ton

Registered, parametrised 1-to-N stream demultiplexer for the simple communication system. It takes one valid/ready input stream carrying a channel select and routes each beat to one of `N_CH` output channels, or to all of them in broadcast mode. Each output channel has a one-entry output register with independent valid/ready backpressure. Beats with an out-of-range select are dropped and counted. The block sits between the link receiver and the per-channel consumers.

## Interface
- `DATA_W`, 8, payload width in bits (≥1)
- `N_CH`, 4, number of output channels (2..16; need not be a power of two)
- `SEL_W`, 2, select width; must satisfy 2^`SEL_W` ≥ `N_CH`
---
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `s_data`  in  `DATA_W`  input payload
- `s_sel`  in  `SEL_W`  destination channel index
- `s_bcast`  in  1  1 = deliver to every channel; `s_sel` is ignored
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`
- `m_data`  out  `N_CH*DATA_W`  channel k occupies bits [k*DATA_W +: DATA_W]
- `m_valid`  out  `N_CH`  per-channel valid
- `m_ready`  in  `N_CH`  per-channel ready
- `err_sel`  out  1  one-cycle pulse: a beat with `s_sel` ≥ `N_CH` was dropped
- `drop_cnt`  out  8  saturating count of dropped beats

## Operation
- Channel register k is free when `!m_valid[k] || m_ready[k]`. A full register being drained in the same cycle counts as free.
- `s_ready` is combinational:
  - `s_bcast=1`: all channels free.
  - `s_bcast=0`, `s_sel<N_CH`: channel `s_sel` free.
  - `s_bcast=0`, `s_sel≥N_CH`: always 1, so the beat is sunk.
  - `s_ready` must not depend on `s_valid`.
- On an accepted unicast beat: channel `s_sel` loads `s_data` and sets `m_valid` to 1.
- On an accepted broadcast beat: every channel loads `s_data` and sets `m_valid` to 1 in the same cycle.
- On an accepted invalid-select beat:
  - No channel changes.
  - `err_sel` is 1 in the next cycle only.
  - `drop_cnt` increments and saturates at 255.
- Drain: when `m_valid[k] && m_ready[k]` and channel k is not being loaded this cycle, `m_valid[k]` goes to 0 and that channel's `m_data` slice is cleared to 0. An idle channel always presents zero data.
- Simultaneous drain and load on the same channel: the load wins. `m_valid[k]` stays 1 and the new data appears. No bubble.
- Stability: while `m_valid[k] && !m_ready[k]`, the channel's data and valid must not change.
- Channels are fully independent. A stalled channel blocks only beats addressed to it, plus all broadcast beats.
- Reset, asserted at any time including mid-transfer:
  - `m_valid`=0, `m_data`=0, `err_sel`=0, `drop_cnt`=0.
  - Any beat in flight is discarded.
  - `s_ready` follows the combinational rule using the cleared state.

## Timing
- Latency: an input accepted at edge n is visible on `m_valid`/`m_data` after edge n.
- Throughput: 1 beat per cycle per channel when the consumer holds `m_ready`=1.
- `err_sel` and `drop_cnt` update at the edge that accepts the bad beat.
- `s_ready` has no registered delay; there is a combinational path from `m_ready` and `s_sel`/`s_bcast` to `s_ready`.
- Reset assertion clears outputs asynchronously. Deassertion is sampled on the next `clk` rising edge.

## Test plan
- **Unicast sweep** (`N_CH`=4, all `m_ready`=1): send 0xA0..0xA3 with sel 0..3 on back-to-back cycles. Expect each channel k to show `m_valid[k]`=1 with 0xA0+k for exactly one cycle, one cycle after its beat. Other channels stay 0.
- **Backpressure** (`m_ready[2]`=0): send sel=2 with 0x55, then sel=2 with 0x66.
  - Expect 0x55 held on ch2 and `s_ready`=0 for the second beat.
  - A following sel=1 beat is still accepted.
  - Raise `m_ready[2]`: expect 0x66 loaded on the same edge that 0x55 drains, with no bubble.
- **Broadcast blocked**: set `m_ready[3]`=0 with ch3 full, then send bcast 0x3C. Expect `s_ready`=0 until ch3 drains, then all four channels show 0x3C in the same cycle.
- **Invalid select** (`N_CH`=3, `SEL_W`=2): send sel=3 with 0xFF 300 times.
  - Expect `s_ready`=1 throughout and one `err_sel` pulse per beat.
  - No channel becomes valid.
  - `drop_cnt` saturates at 255.
- **Reset mid-operation**: with ch0 and ch1 full and stalled, pulse `rst_n` low asynchronously between clock edges. Expect `m_valid`=0, `m_data`=0 and `drop_cnt`=0 immediately. After release, a sel=0 beat 0x11 is delivered normally.

Source files
------------

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer: unicast by select, broadcast to all,
// out-of-range selects are sunk, flagged and counted.

module demux_stream_chan #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              rdy,
  output logic              vld,
  output logic [DATA_W-1:0] data,
  output logic              free
);
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load has priority over drain so a drained slot refills with no bubble.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = din;
    end else if (vld_q && rdy) begin
      vld_d  = 1'b0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign free = !vld_q || rdy;
  assign vld  = vld_q;
  assign data = data_q;
endmodule

module demux_stream_1ton #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      s_data,
  input  logic [SEL_W-1:0]       s_sel,
  input  logic                   s_bcast,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [N_CH*DATA_W-1:0] m_data,
  output logic [N_CH-1:0]        m_valid,
  input  logic [N_CH-1:0]        m_ready,
  output logic                   err_sel,
  output logic [7:0]             drop_cnt
);
  logic [N_CH-1:0]             sel_hit, ch_free, ch_load, ch_vld;
  logic [N_CH-1:0][DATA_W-1:0] ch_data;
  logic                        sel_ok, accept, bad_beat;
  logic                        err_q, err_d;
  logic [7:0]                  cnt_q, cnt_d;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign sel_hit[k] = (s_sel == SEL_W'(k));
    demux_stream_chan #(.DATA_W(DATA_W)) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .load (ch_load[k]),
      .din  (s_data),
      .rdy  (m_ready[k]),
      .vld  (ch_vld[k]),
      .data (ch_data[k]),
      .free (ch_free[k])
    );
  end

  // An out-of-range select matches no channel; such beats are always accepted.
  assign sel_ok   = |sel_hit;
  assign s_ready  = s_bcast ? &ch_free : (sel_ok ? |(sel_hit & ch_free) : 1'b1);
  assign accept   = s_valid && s_ready;
  assign ch_load  = {N_CH{accept}} & ({N_CH{s_bcast}} | sel_hit);
  assign bad_beat = accept && !s_bcast && !sel_ok;

  always_comb begin
    err_d = bad_beat;
    cnt_d = cnt_q;
    if (bad_beat && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign m_valid  = ch_vld;
  assign m_data   = ch_data;
  assign err_sel  = err_q;
  assign drop_cnt = cnt_q;
endmodule
